// File: rtl/ifetch_queue_if.sv
// Bus bundle for the instruction prefetch queue.
// The master modport is the queue itself. It drives the word-fetch request and the
// instruction stream, and it receives fetch responses plus the redirect/stall controls.
// The slave modport is the memory and decoder side seen from outside the queue.
interface ifetch_queue_if #(
  parameter int RV = 32
);
  logic          fetch_req;
  logic [RV-1:0] fetch_addr;
  logic          fetch_ack;
  logic [31:0]   fetch_data;
  logic          fetch_fault;
  logic          redirect;
  logic [RV-1:0] redirect_pc;
  logic          stall;
  logic [15:0]   ins;
  logic          idone;
  logic [RV-1:0] ins_pc;
  logic          ins_fault;

  modport master (
    output fetch_req, fetch_addr, ins, idone, ins_pc, ins_fault,
    input  fetch_ack, fetch_data, fetch_fault, redirect, redirect_pc, stall
  );

  modport slave (
    input  fetch_req, fetch_addr, ins, idone, ins_pc, ins_fault,
    output fetch_ack, fetch_data, fetch_fault, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue for the 16-bit decoder.
// Fetches aligned 32-bit words and splits each word into two halfword entries.
// It presents one entry per cycle together with its PC.
// Queue space is reserved when a fetch is issued, so a returning word always fits.
// A redirect flushes everything.
// A fetch that is still outstanding when the redirect arrives is completed and its data dropped.
// A faulting fetch leaves a single fault marker in the queue and parks the fetcher until the next redirect.
module ifetch_queue #(
  parameter int RV    = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  ifetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HALT
  } state_t;

  state_t        state_q, state_d;
  logic [RV-1:0] pc_q, pc_d;
  logic [RV-1:0] fetch_addr_q, fetch_addr_d;
  logic [RV-1:0] head_pc_q, head_pc_d;
  logic [16:0]   mem_q [DEPTH];
  logic [16:0]   mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] wr_nxt;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    push_cnt;
  logic [16:0]   push_e0;
  logic [16:0]   push_e1;
  logic [16:0]   head;
  logic          empty;
  logic          idone;

  assign head   = mem_q[rd_q];
  assign empty  = (count_q == '0);
  assign idone  = !empty && !bus.stall && !bus.redirect;
  assign wr_nxt = wr_q + AW'(1);

  assign bus.idone      = idone;
  assign bus.ins        = head[15:0];
  assign bus.ins_fault  = head[16];
  assign bus.ins_pc     = head_pc_q;
  assign bus.fetch_req  = (state_q == REQ) || (state_q == DISCARD);
  assign bus.fetch_addr = fetch_addr_q;

  // Fetch sequencer: issue a word fetch when two slots are free, then decide what the response pushes
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    push_cnt     = 2'd0;
    push_e0      = '0;
    push_e1      = '0;

    case (state_q)
      IDLE: begin
        if (!bus.redirect && (count_q <= ISSUE_MAX)) begin
          fetch_addr_d = pc_q & ~RV'(3);
          state_d      = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          state_d = bus.fetch_ack ? IDLE : DISCARD;
        end else if (bus.fetch_ack) begin
          if (bus.fetch_fault) begin
            push_cnt = 2'd1;
            push_e0  = {1'b1, 16'h0000};
            state_d  = HALT;
          end else begin
            if (pc_q[1]) begin
              push_cnt = 2'd1;
              push_e0  = {1'b0, bus.fetch_data[31:16]};
            end else begin
              push_cnt = 2'd2;
              push_e0  = {1'b0, bus.fetch_data[15:0]};
              push_e1  = {1'b0, bus.fetch_data[31:16]};
            end
            pc_d    = fetch_addr_q + RV'(4);
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.fetch_ack) begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (bus.redirect) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.redirect) begin
      pc_d = bus.redirect_pc & ~RV'(1);
    end
  end

  // Queue bookkeeping: write pushed entries, pop on idone, and flush everything on redirect
  always_comb begin
    mem_d     = mem_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;

    if (push_cnt != 2'd0) begin
      mem_d[wr_q] = push_e0;
    end
    if (push_cnt == 2'd2) begin
      mem_d[wr_nxt] = push_e1;
    end
    wr_d = wr_q + AW'(push_cnt);

    if (idone) begin
      rd_d      = rd_q + AW'(1);
      head_pc_d = head_pc_q + RV'(2);
    end

    count_d = count_q + CW'(push_cnt) - CW'(idone);

    if (bus.redirect) begin
      rd_d      = '0;
      wr_d      = '0;
      count_d   = '0;
      head_pc_d = bus.redirect_pc & ~RV'(1);
    end
  end

  // State and queue registers; reset abandons any outstanding fetch immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      fetch_addr_q <= '0;
      head_pc_q    <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

endmodule
